cpu_core_sequencer: RTL and testbench
=====================================

CPU_CORE_SEQUENCER -- requirements
Module: cpu_core_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width (instruction words).
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width (ADDR_W >= PC_W).
REQ-003 SHALL have parameter DATA_W, default 32, instruction/data width (fixed field layout assumes >= 32).
REQ-004 SHALL have port Clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-low (0 = reset).
REQ-006 SHALL have port start  in  1  one-cycle pulse, leaves IDLE.
REQ-007 SHALL have ports busy, halted  out  1 each  busy = not IDLE/HALTED; halted = in HALTED.
REQ-008 SHALL have port pc  out  PC_W  current program counter.
REQ-009 SHALL have ports mem_en out 1, mem_rw out 1 (1 read, 0 write), mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W, mem_ready in 1.
REQ-010 SHALL have ports rf_raddr1, rf_raddr2 out 4; rf_rdata1, rf_rdata2 in DATA_W; rf_we out 1; rf_waddr out 4; rf_wdata out DATA_W.
REQ-011 SHALL have ports alu_op out 4, alu_s out 1, alu_shamt out 5, alu_imm out 16, alu_result in DATA_W, alu_flags in 4 ({N,Z,C,V}); flags out 4 (architectural flags).

Function
REQ-012 SHALL decode IR: Cond[31:28], OpCode[27:24], S[23], Rd[22:19], Rs2[18:15], Rs1[14:11], Shamt[10:6], Imm16[18:3]; rf_raddr1=Rs1, rf_raddr2=Rs2, alu_op/alu_s/alu_shamt/alu_imm driven from IR.
REQ-013 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, HALTED.
REQ-014 IDLE: start=1 -> FETCH; start ignored in every other state.
REQ-015 FETCH: mem_en=1, mem_rw=1, mem_addr=zero-extended pc; on mem_ready=1 capture IR, pc<=pc+1 (wraps 2^PC_W-1 -> 0), -> DECODE; mem_ready=0 holds FETCH indefinitely.
REQ-016 DECODE: one cycle for register read -> EXEC.
REQ-017 EXEC: evaluate Cond against flags (ARM table: 0000 EQ ... 1101 LE, 1110 AL, 1111 never); fail -> FETCH with no rf/flag/mem/pc side effects.
REQ-018 EXEC, OpCode 0x0-0xB (ALU class): rf_we=1 one cycle, rf_waddr=Rd, rf_wdata=alu_result; flags<=alu_flags iff S=1; -> FETCH.
REQ-019 EXEC, OpCode 0xC (LDR): -> MEM read at mem_addr=rf_rdata1[ADDR_W-1:0]; on mem_ready rf_we=1, rf_waddr=Rd, rf_wdata=mem_rdata; -> FETCH.
REQ-020 EXEC, OpCode 0xD (STR): -> MEM write, mem_rw=0, mem_addr=rf_rdata1[ADDR_W-1:0], mem_wdata=rf_rdata2; complete on mem_ready; -> FETCH.
REQ-021 EXEC, OpCode 0xF (HALT): -> HALTED; stays until Reset; no memory or register activity.
REQ-022 Throughput with mem_ready tied 1: ALU/condition-fail instruction 3 cycles; LDR/STR 4 cycles.
REQ-023 mem_en SHALL be 0 outside FETCH/MEM; mem_ready outside FETCH/MEM SHALL be ignored; rf_we SHALL be 0 except REQ-018/019 cycle.
REQ-024 mem_addr, mem_rw, mem_wdata SHALL remain stable while mem_en=1 and mem_ready=0.

Reset
REQ-025 Reset=0 SHALL immediately force IDLE, pc=0, IR=0, flags=0, mem_en=0, rf_we=0, busy=0, halted=0, all other outputs 0.
REQ-026 Reset asserted mid-FETCH/MEM SHALL abort the access with no rf write; Reset release restarts only on next start.

Configuration
REQ-027 Macro CPU_SEQ_BRANCH_EN defined: OpCode 0xE is branch; in EXEC with Cond passing pc<=Imm16[PC_W-1:0], -> FETCH (3 cycles).
REQ-028 Macro CPU_SEQ_BRANCH_EN undefined: OpCode 0xE treated as ALU class per REQ-018.

Verification
REQ-029 Program at 0: ALU op Rd=3, alu_result=20, S=1, alu_flags=0000; mem_ready=1 -> rf_we pulse cycle 3 after FETCH entry, rf_waddr=3, rf_wdata=20, flags=0000, pc=1.
REQ-030 LDR Rd=5, rf_rdata1=0x0040, mem_ready low 3 cycles then 1 with mem_rdata=0xDEADBEEF -> mem_addr held 0x0040, rf_wdata=0xDEADBEEF to R5.
REQ-031 flags Z=1, instruction Cond=0001 (NE) STR -> no mem_en in MEM, no rf_we, next FETCH at pc+1.
REQ-032 pc=2^PC_W-1 executes ALU op -> pc wraps to 0; HALT word 0x0F000000 -> halted=1, busy=0, start ignored.
REQ-033 Reset=0 asserted during MEM write -> mem_en drops same time step, state IDLE, pc=0.
REQ-034 With CPU_SEQ_BRANCH_EN, Cond=1110 OpCode 0xE Imm16=0x0007 -> next fetch mem_addr=7; without macro -> rf write, fetch at pc+1.

Source files
------------

// File: rtl/cpu_core_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving external memory, register file and ALU.
// Latency: ALU or condition-failed instruction 3 cycles, LDR/STR 4 cycles with mem_ready tied high.
// Backpressure: FETCH and MEM hold outputs stable until mem_ready; CPU_SEQ_BRANCH_EN enables opcode 0xE branch.
module cpu_core_sequencer #(
    parameter int PC_W   = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    output logic              busy,
    output logic              halted,
    output logic [PC_W-1:0]   pc,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [3:0]        rf_raddr1,
    output logic [3:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        alu_op,
    output logic              alu_s,
    output logic [4:0]        alu_shamt,
    output logic [15:0]       alu_imm,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_LDR  = 4'hC;
    localparam logic [3:0] OP_STR  = 4'hD;
    localparam logic [3:0] OP_BR   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [3:0]          flags_q, flags_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   mwdata_q, mwdata_d;
    logic                mread_q, mread_d;

    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s_bit;
    logic [3:0]  rd;
    logic [15:0] imm16;
    logic        unused_bits;

    assign cond   = ir_q[31:28];
    assign opcode = ir_q[27:24];
    assign s_bit  = ir_q[23];
    assign rd     = ir_q[22:19];
    assign imm16  = ir_q[18:3];

    assign rf_raddr1 = ir_q[14:11];
    assign rf_raddr2 = ir_q[18:15];
    assign rf_waddr  = rd;
    assign alu_op    = opcode;
    assign alu_s     = s_bit;
    assign alu_shamt = ir_q[10:6];
    assign alu_imm   = imm16;

    assign pc     = pc_q;
    assign flags  = flags_q;
    assign busy   = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted = (state_q == S_HALTED);

    assign unused_bits = ^{rf_rdata1[DATA_W-1:ADDR_W], ir_q[2:0]};

    // ARM condition table over {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cf;
            4'h3:    cond_pass = !cf;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cf && !z;
            4'h9:    cond_pass = !cf || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            flags_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mread_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            flags_q  <= flags_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mread_q  <= mread_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        flags_d   = flags_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        mread_d   = mread_q;
        mem_en    = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_we     = 1'b0;
        rf_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_en   = 1'b1;
                mem_rw   = 1'b1;
                mem_addr = ADDR_W'(pc_q);
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                // HALT is unconditional so the canonical 0x0F000000 word stops the core
                if (opcode == OP_HALT) begin
                    state_d = S_HALTED;
                end else if (cond_pass(cond, flags_q)) begin
                    case (opcode)
                        OP_LDR: begin
                            maddr_d = rf_rdata1[ADDR_W-1:0];
                            mread_d = 1'b1;
                            state_d = S_MEM;
                        end
                        OP_STR: begin
                            maddr_d  = rf_rdata1[ADDR_W-1:0];
                            mwdata_d = rf_rdata2;
                            mread_d  = 1'b0;
                            state_d  = S_MEM;
                        end
`ifdef CPU_SEQ_BRANCH_EN
                        OP_BR: pc_d = PC_W'(imm16);
`endif
                        default: begin
                            rf_we    = 1'b1;
                            rf_wdata = alu_result;
                            if (s_bit) flags_d = alu_flags;
                        end
                    endcase
                end
            end
            S_MEM: begin
                // address/data come from registers latched in EXEC so they cannot move while stalled
                mem_en    = 1'b1;
                mem_rw    = mread_q;
                mem_addr  = maddr_q;
                mem_wdata = mread_q ? '0 : mwdata_q;
                if (mem_ready) begin
                    if (mread_q) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_rdata;
                    end
                    state_d = S_FETCH;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_core_sequencer.sv
// Directed bench for cpu_core_sequencer: memory, register file and ALU are driven by hand per instruction.
module tb_cpu_core_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        busy, halted;
    logic [7:0]  pc;
    logic        mem_en, mem_rw;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  alu_op;
    logic        alu_s;
    logic [4:0]  alu_shamt;
    logic [15:0] alu_imm;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_pc;

    cpu_core_sequencer #(.PC_W(8), .ADDR_W(16), .DATA_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .busy(busy), .halted(halted), .pc(pc),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_op(alu_op), .alu_s(alu_s), .alu_shamt(alu_shamt), .alu_imm(alu_imm),
        .alu_result(alu_result), .alu_flags(alu_flags), .flags(flags)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] enc(input logic [3:0] c, input logic [3:0] op, input logic s,
                                        input logic [3:0] rd, input logic [3:0] rs2, input logic [3:0] rs1);
        return {c, op, s, rd, rs2, rs1, 11'b0};
    endfunction

    // Called with the core in FETCH; stalls for 'waits' cycles, then delivers the instruction.
    task automatic do_fetch(input logic [31:0] instr, input int waits);
        for (int w = 0; w <= waits; w++) begin
            check("fetch_en", mem_en, 1);
            check("fetch_rw", mem_rw, 1);
            check("fetch_addr", mem_addr, {24'd0, exp_pc});
            if (w == waits) begin
                mem_rdata = instr;
                mem_ready = 1'b1;
            end
            tick();
        end
        mem_ready = 1'b0;
        exp_pc    = exp_pc + 8'd1;
        check("pc_inc", pc, {24'd0, exp_pc});
        check("decode_no_we", rf_we, 0);
    endtask

    initial begin
        Reset = 1'b0; start = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; alu_result = '0; alu_flags = '0;
        exp_pc = 8'd0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_flags", flags, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_alu_op", alu_op, 0);
        tick(); Reset = 1'b1;
        mem_ready = 1'b1;
        tick(); tick();
        check("idle_busy", busy, 0);
        check("idle_mem_en", mem_en, 0);
        mem_ready = 1'b0;

        start = 1'b1; tick(); start = 1'b0;
        check("fetch_busy", busy, 1);

        // ALU, S=1, Rd=3 <- 20 with flags 0000
        do_fetch(enc(4'hE, 4'h1, 1'b1, 4'd3, 4'd2, 4'd1), 0);
        check("dec_raddr1", rf_raddr1, 1);
        check("dec_raddr2", rf_raddr2, 2);
        check("dec_alu_op", alu_op, 1);
        check("dec_alu_s", alu_s, 1);
        alu_result = 32'd20; alu_flags = 4'b0000;
        tick();
        check("alu_we", rf_we, 1);
        check("alu_waddr", rf_waddr, 3);
        check("alu_wdata", rf_wdata, 20);
        tick();
        check("alu_we_drop", rf_we, 0);
        check("alu_flags0", flags, 0);
        check("alu_pc", pc, 1);

        // ALU, S=1 sets Z
        do_fetch(enc(4'hE, 4'h3, 1'b1, 4'd2, 4'd0, 4'd0), 0);
        alu_flags = 4'b0100;
        tick();
        check("alu2_we", rf_we, 1);
        tick();
        check("alu2_flags", flags, 4'b0100);

        // LDR R5, [R4]; instruction fetch stalled 2 cycles, data stalled 3 cycles
        do_fetch(enc(4'hE, 4'hC, 1'b0, 4'd5, 4'd0, 4'd4), 2);
        check("ldr_raddr1", rf_raddr1, 4);
        rf_rdata1 = 32'h0000_0040;
        tick();
        check("ldr_exec_we", rf_we, 0);
        check("ldr_exec_en", mem_en, 0);
        tick();
        rf_rdata1 = 32'h0000_9999;
        mem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("ldr_wait_en", mem_en, 1);
            check("ldr_wait_rw", mem_rw, 1);
            check("ldr_wait_addr", mem_addr, 32'h40);
            check("ldr_wait_we", rf_we, 0);
            tick();
        end
        mem_rdata = 32'hDEAD_BEEF; mem_ready = 1'b1;
        #1;
        check("ldr_we", rf_we, 1);
        check("ldr_waddr", rf_waddr, 5);
        check("ldr_wdata", rf_wdata, 32'hDEAD_BEEF);
        tick(); mem_ready = 1'b0;

        // STR with NE while Z=1: skipped
        do_fetch(enc(4'h1, 4'hD, 1'b0, 4'd0, 4'd3, 4'd6), 0);
        tick();
        check("strne_en", mem_en, 0);
        check("strne_we", rf_we, 0);
        tick();
        check("strne_flags", flags, 4'b0100);

        // STR taken, one stall cycle
        do_fetch(enc(4'hE, 4'hD, 1'b0, 4'd0, 4'd3, 4'd6), 0);
        rf_rdata1 = 32'h0000_0080; rf_rdata2 = 32'h1234_5678;
        tick(); tick();
        rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
        for (int i = 0; i < 2; i++) begin
            check("str_en", mem_en, 1);
            check("str_rw", mem_rw, 0);
            check("str_addr", mem_addr, 32'h80);
            check("str_wdata", mem_wdata, 32'h1234_5678);
            check("str_we", rf_we, 0);
            if (i == 0) tick();
        end
        mem_ready = 1'b1;
        #1;
        check("str_done_we", rf_we, 0);
        tick(); mem_ready = 1'b0;

        // Opcode 0xE, cond AL, Imm16 = 7
        do_fetch(32'hEE00_0038, 0);
        check("br_imm", alu_imm, 7);
        alu_result = 32'h55;
        tick();
`ifdef CPU_SEQ_BRANCH_EN
        check("br_we", rf_we, 0);
        tick();
        exp_pc = 8'd7;
`else
        check("e_alu_we", rf_we, 1);
        check("e_alu_wdata", rf_wdata, 32'h55);
        tick();
`endif

        // Never-condition instructions with S=1 up to pc 255: no writes, no flag change
        alu_flags = 4'hF;
        for (int i = 0; i < 300 && exp_pc != 8'd255; i++) begin
            do_fetch(enc(4'hF, 4'h1, 1'b1, 4'd1, 4'd1, 4'd1), 0);
            tick();
            check("nv_we", rf_we, 0);
            tick();
        end
        check("nv_reach_255", pc, 255);
        check("nv_flags", flags, 4'b0100);

        // ALU at pc 255 with S=0: pc wraps, flags unchanged
        do_fetch(enc(4'hE, 4'h2, 1'b0, 4'd1, 4'd0, 4'd0), 0);
        check("wrap_pc", pc, 0);
        tick();
        check("wrap_we", rf_we, 1);
        tick();
        check("wrap_flags", flags, 4'b0100);

        // HALT
        do_fetch(32'h0F00_0000, 0);
        tick();
        check("halt_exec_en", mem_en, 0);
        check("halt_exec_we", rf_we, 0);
        tick();
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 0);
        start = 1'b1; tick(); start = 1'b0; tick();
        check("halt_stay", halted, 1);
        check("halt_mem_en", mem_en, 0);
        check("halt_pc", pc, 1);

        // Reset out of HALTED, restart, reset again mid STR
        Reset = 1'b0; #1;
        check("rst2_halted", halted, 0);
        check("rst2_pc", pc, 0);
        tick(); Reset = 1'b1; tick();
        check("rst2_idle", busy, 0);
        start = 1'b1; tick(); start = 1'b0;
        exp_pc = 8'd0;
        do_fetch(enc(4'hE, 4'hD, 1'b0, 4'd0, 4'd3, 4'd6), 0);
        rf_rdata1 = 32'h0000_0080; rf_rdata2 = 32'hCAFE_0001;
        tick(); tick();
        check("mid_mem_en", mem_en, 1);
        Reset = 1'b0; #1;
        check("mid_rst_en", mem_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_flags", flags, 0);
        tick(); Reset = 1'b1; mem_ready = 1'b1; tick(); tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_en", mem_en, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
